uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter PAYLOAD_BITS, default 8: bits per byte; shall match the driven uart_tx.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: inter-byte watchdog limit (used only under UART_TX_ARB_WATCHDOG_EN).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-007 req_last  input  NUM_REQ  per-requester flag: current byte ends the packet.
REQ-008 req_data  input  NUM_REQ*PAYLOAD_BITS  per-requester byte; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-009 req_ready  output  NUM_REQ  one-cycle accept strobe per requester.
REQ-010 tx_en  output  1  start strobe to uart_tx.
REQ-011 tx_data  output  PAYLOAD_BITS  byte to uart_tx.
REQ-012 tx_busy  input  1  busy flag from uart_tx.
REQ-013 grant_valid  output  1  a requester currently owns the transmitter.
REQ-014 grant_id  output  $clog2(NUM_REQ)  index of the owning requester.
REQ-015 err_timeout  output  1  one-cycle pulse on watchdog release (tied 0 without the macro).

Function
REQ-016 The FSM shall have states IDLE, ISSUE and WAIT_DONE.
REQ-017 IDLE: if any req_valid is high, the block shall register the round-robin winner into grant_id, set grant_valid and enter ISSUE on the next cycle; otherwise it shall remain in IDLE.
REQ-018 Round-robin: search starts at priority pointer ptr and ascends modulo NUM_REQ; the first valid index wins.
REQ-019 ISSUE: when req_valid[grant_id]=1 and tx_busy=0, the block shall, in that same cycle, assert tx_en=1, req_ready[grant_id]=1 and tx_data=req_data[grant_id], capture req_last[grant_id], and enter WAIT_DONE.
REQ-020 ISSUE with req_valid[grant_id]=0 or tx_busy=1: the block shall hold the grant with no strobes.
REQ-021 WAIT_DONE: the block shall skip the first cycle (in which tx_busy rises), then wait for tx_busy=0.
REQ-022 WAIT_DONE exit: if the captured last=1, the block shall clear grant_valid, set ptr=(grant_id+1) mod NUM_REQ and enter IDLE; otherwise it shall return to ISSUE with the same grant.
REQ-023 Packet lock: no other requester shall receive req_ready while grant_valid=1, regardless of its req_valid.
REQ-024 At most one req_ready bit shall be high in any cycle; req_ready and tx_en shall be high only in the same cycle, for exactly one cycle per byte.
REQ-025 Minimum latency: req_valid high in IDLE at cycle N gives tx_en at cycle N+1.
REQ-026 Bytes shall be presented to uart_tx in requester order, never dropped or duplicated.
REQ-027 tx_data shall be zero whenever tx_en=0.

Reset
REQ-028 While resetn=0: state=IDLE, ptr=0, grant_valid=0, grant_id=0, req_ready=0, tx_en=0, tx_data=0, err_timeout=0.
REQ-029 Reset asserted mid-packet shall abandon the packet; after release, arbitration restarts from ptr=0.

Configuration
REQ-030 Macro UART_TX_ARB_WATCHDOG_EN defined: a counter shall run in ISSUE while req_valid[grant_id]=0 after the packet's first byte.
REQ-031 At count TIMEOUT_CYCLES, the block shall pulse err_timeout, release the grant, advance ptr as in REQ-022 and enter IDLE.
REQ-032 Any accepted byte shall clear the counter.
REQ-033 Macro undefined: no counter shall exist, err_timeout shall be constant 0, and the grant shall be held indefinitely.

Verification
REQ-034 Requester 0 sends one byte 0xA5 with last=1 -> tx_en one cycle after valid, tx_data=0xA5, req_ready[0] same cycle, grant_valid drops after tx_busy falls, ptr=1.
REQ-035 All 4 requesters valid with single-byte packets 0x10..0x13 from reset -> bytes transmitted in order 0x10, 0x11, 0x12, 0x13; then requester 0 again is served after requester 3.
REQ-036 Requester 2 sends a 3-byte packet 0x01, 0x02, 0x03 (last on the third byte) while requester 1 holds valid -> all three bytes from requester 2 are transmitted before requester 1 gets any req_ready.
REQ-037 Reset pulsed during WAIT_DONE of a 2-byte packet -> all outputs at their reset values the next cycle; the second byte is never issued; the next grant follows ptr=0.
REQ-038 With UART_TX_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16, requester 1 sends one non-last byte then drops valid -> err_timeout pulses 16 cycles after ISSUE re-entry, grant is released and requester 2 is served next.
REQ-039 Hold tx_busy=1 externally in ISSUE -> no tx_en and no req_ready until tx_busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx among NUM_REQ requesters.
// Optional inter-byte watchdog is built when UART_TX_ARB_WATCHDOG_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int PAYLOAD_BITS   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            tx_en,
    output logic [PAYLOAD_BITS-1:0]         tx_data,
    input  logic                            tx_busy,
    output logic                            grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            err_timeout
);
    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [1:0]              state_r;
    logic [IDW-1:0]          ptr_r;
    logic [IDW-1:0]          grant_id_r;
    logic [IDW-1:0]          win_s;
    logic [IDW-1:0]          cand_s;
    logic [IDW-1:0]          ptr_next_s;
    logic                    grant_valid_r;
    logic                    last_r;
    logic                    skip_r;
    logic                    any_valid_s;
    logic                    accept_s;
    logic                    wait_exit_s;
    logic                    timeout_s;
    logic [NUM_REQ-1:0]      req_ready_s;
    logic [PAYLOAD_BITS-1:0] tx_data_s;

    // Round-robin winner: scan from the far end so the index nearest ptr is the last to overwrite.
    always_comb begin
        win_s       = ptr_r;
        cand_s      = {IDW{1'b0}};
        any_valid_s = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s      = IDW'((int'(ptr_r) + k) % NUM_REQ);
            win_s       = req_valid[cand_s] ? cand_s : win_s;
            any_valid_s = any_valid_s | req_valid[cand_s];
        end
    end

    assign ptr_next_s  = (grant_id_r == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : grant_id_r + IDW'(1);
    assign accept_s    = resetn & (state_r == ST_ISSUE) & req_valid[grant_id_r] & ~tx_busy;
    assign wait_exit_s = (state_r == ST_WAIT_DONE) & ~skip_r & ~tx_busy;

    // Byte hand-off strobes: same-cycle handshake, so these follow the accept condition directly.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        tx_data_s   = {PAYLOAD_BITS{1'b0}};
        if (accept_s) begin
            req_ready_s[grant_id_r] = 1'b1;
            tx_data_s               = req_data[int'(grant_id_r)*PAYLOAD_BITS +: PAYLOAD_BITS];
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    assign req_ready   = req_ready_s;
    assign tx_en       = accept_s;
    assign tx_data     = tx_data_s;
    assign grant_valid = resetn & grant_valid_r;
    assign grant_id    = resetn ? grant_id_r : {IDW{1'b0}};

    // Grant FSM: IDLE arbitrates, ISSUE hands over one byte, WAIT_DONE tracks the uart_tx frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            ptr_r         <= {IDW{1'b0}};
            grant_id_r    <= {IDW{1'b0}};
            grant_valid_r <= 1'b0;
            last_r        <= 1'b0;
            skip_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        grant_id_r    <= win_s;
                        grant_valid_r <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (accept_s) begin
                        last_r  <= req_last[grant_id_r];
                        skip_r  <= 1'b1;
                        state_r <= ST_WAIT_DONE;
                    end else if (timeout_s) begin
                        grant_valid_r <= 1'b0;
                        ptr_r         <= ptr_next_s;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT_DONE: begin
                    // First cycle is skipped: uart_tx only raises busy the cycle after tx_en.
                    skip_r <= 1'b0;
                    if (wait_exit_s && last_r) begin
                        grant_valid_r <= 1'b0;
                        ptr_r         <= ptr_next_s;
                        state_r       <= ST_IDLE;
                    end else if (wait_exit_s) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    grant_valid_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_cnt_r;
    logic           first_done_r;
    logic           err_timeout_r;

    assign timeout_s = (state_r == ST_ISSUE) & first_done_r & ~req_valid[grant_id_r] &
                       (wd_cnt_r == WDW'(TIMEOUT_CYCLES - 1));

    // Inter-byte watchdog: counts starved ISSUE cycles once the packet has started.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt_r      <= {WDW{1'b0}};
            first_done_r  <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= timeout_s;
            if (state_r == ST_IDLE) begin
                wd_cnt_r     <= {WDW{1'b0}};
                first_done_r <= 1'b0;
            end else if (accept_s) begin
                wd_cnt_r     <= {WDW{1'b0}};
                first_done_r <= 1'b1;
            end else if (timeout_s) begin
                wd_cnt_r <= {WDW{1'b0}};
            end else if ((state_r == ST_ISSUE) && first_done_r && !req_valid[grant_id_r]) begin
                wd_cnt_r <= wd_cnt_r + WDW'(1);
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
        end
    end

    assign err_timeout = resetn & err_timeout_r;
`else
    assign timeout_s   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomised packet traffic
// against a packet-level round-robin model. Define UART_TX_ARB_WATCHDOG_EN to exercise the watchdog.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int PB    = 8;
    localparam int TO    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N*PB-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          tx_en;
    logic [PB-1:0] tx_data;
    logic          tx_busy;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic          err_timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(PB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus store: {last, byte} per requester, with driver and scoreboard read pointers.
    logic [8:0] mem [N][DEPTH];
    int         wr_idx [N];
    int         drv_idx [N];
    int         sb_idx [N];
    logic       acc_flag [N];
    logic       gate_en = 1'b0;
    logic       hold_busy = 1'b0;
    logic       start_busy = 1'b0;
    int         busy_len = 0;
    int         busy_cnt = 0;

    // Packet-level reference model.
    logic       mon_en = 1'b0;
    int         cyc = 0;
    int         m_ptr = 0;
    int         owner = -1;
    int         exp_grant = 0;
    int         release_at = -1;
    int         wd_at = -1;
    logic       grant_pend = 1'b0;
    logic       lat_pend = 1'b0;
    logic [7:0] tx_log [$];

    always @(negedge clk) begin
        if (mon_en) begin
            int idx;
            logic [8:0] ent;
            cyc++;
            check_eq("ready_onehot", ((req_ready & (req_ready - 4'd1)) == 4'd0), 1'b1);
            check_eq("en_vs_ready", tx_en, |req_ready);
            if (!tx_en) check_eq("data_idle_zero", tx_data, 8'h00);
            if (tx_busy) check_eq("no_en_while_busy", tx_en, 1'b0);
            check_eq("err_timeout", err_timeout, (cyc == wd_at));
            if (lat_pend && !tx_busy) check_eq("latency", tx_en, 1'b1);
            lat_pend = 1'b0;
            if (grant_pend) begin
                check_eq("grant_valid_set", grant_valid, 1'b1);
                check_eq("grant_id", grant_id, exp_grant);
                owner      = exp_grant;
                grant_pend = 1'b0;
            end
            if (cyc == wd_at) begin
                check_eq("wd_release", grant_valid, 1'b0);
                m_ptr = (owner + 1) % N;
                owner = -1;
                wd_at = -1;
            end else if (cyc == release_at) begin
                check_eq("release", grant_valid, 1'b0);
                owner      = -1;
                release_at = -1;
            end else begin
                check_eq("grant_held", grant_valid, (owner >= 0));
            end
            if (owner < 0 && req_valid != '0) begin
                exp_grant = -1;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (req_valid[j]) begin
                        exp_grant = j;
                        break;
                    end
                end
                grant_pend = 1'b1;
                lat_pend   = 1'b1;
            end
            if (tx_en) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                check_eq("issue_owner", idx, owner);
                check_eq("expected_pending", (sb_idx[idx] < wr_idx[idx]), 1'b1);
                ent = mem[idx][sb_idx[idx] % DEPTH];
                check_eq("tx_byte", tx_data, ent[7:0]);
                sb_idx[idx]++;
                acc_flag[idx] = 1'b1;
                tx_log.push_back(tx_data);
                busy_len   = $urandom_range(1, 5);
                start_busy = 1'b1;
                wd_at      = -1;
                if (ent[8]) begin
                    release_at = cyc + busy_len + 2;
                    m_ptr      = (idx + 1) % N;
                end
`ifdef UART_TX_ARB_WATCHDOG_EN
                else wd_at = cyc + busy_len + 2 + TO;
`endif
            end
        end
    end

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][wr_idx[r]] = {l, d};
        wr_idx[r]++;
    endtask

    // One clock: requesters present bytes, uart_tx busy emulation follows each tx_en.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i]  = 1'b0;
                drv_idx[i]++;
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && drv_idx[i] < wr_idx[i] && (!gate_en || $urandom_range(0, 3) != 0)) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = mem[i][drv_idx[i]][8];
                req_data[i*PB +: PB] = mem[i][drv_idx[i]][7:0];
            end
        end
        if (start_busy) begin
            busy_cnt   = busy_len;
            start_busy = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = hold_busy | (busy_cnt > 0);
    endtask

    function automatic logic all_done();
        logic d;
        d = 1'b1;
        for (int i = 0; i < N; i++) if (sb_idx[i] != wr_idx[i]) d = 1'b0;
        return d;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !(all_done() && owner < 0 && !grant_pend)) begin
            step();
            n++;
        end
        check_eq("drain_in_budget", (n < budget), 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        mon_en     = 1'b0;
        resetn     = 1'b0;
        req_valid  = '0;
        hold_busy  = 1'b0;
        busy_cnt   = 0;
        start_busy = 1'b0;
        tx_busy    = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr_idx[i]   = 0;
            drv_idx[i]  = 0;
            sb_idx[i]   = 0;
            acc_flag[i] = 1'b0;
        end
        repeat (cycles) begin
            @(negedge clk);
            check_eq("rst_req_ready", req_ready, 4'h0);
            check_eq("rst_tx_en", tx_en, 1'b0);
            check_eq("rst_tx_data", tx_data, 8'h00);
            check_eq("rst_grant_valid", grant_valid, 1'b0);
            check_eq("rst_grant_id", grant_id, 2'd0);
            check_eq("rst_err_timeout", err_timeout, 1'b0);
        end
        m_ptr      = 0;
        owner      = -1;
        grant_pend = 1'b0;
        lat_pend   = 1'b0;
        release_at = -1;
        wd_at      = -1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic check_log(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                             input int n);
        logic [7:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        check_eq({tag, "_count"}, tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++) check_eq({tag, "_order"}, tx_log[i], e[i]);
        tx_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int total;
        resetn    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        do_reset(3);

        // Single byte 0xA5 from requester 0, then ptr=1 makes requester 1 win a tie with 0.
        push(0, 8'hA5, 1'b1);
        drain(50);
        check_log("a5", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        push(0, 8'h20, 1'b1);
        push(1, 8'h21, 1'b1);
        drain(80);
        check_log("ptr1", 8'h21, 8'h20, 8'h00, 8'h00, 8'h00, 2);

        // All four requesters from reset, requester 0 queued again behind requester 3.
        do_reset(1);
        for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b1);
        push(0, 8'h14, 1'b1);
        drain(200);
        check_log("rr", 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 5);

        // Packet lock: 3-byte packet from requester 2 completes before requester 1.
        push(2, 8'h01, 1'b0);
        push(2, 8'h02, 1'b0);
        push(2, 8'h03, 1'b1);
        step();
        step();
        push(1, 8'h40, 1'b1);
        drain(200);
        check_log("lock", 8'h01, 8'h02, 8'h03, 8'h40, 8'h00, 4);

        // Reset in WAIT_DONE of a 2-byte packet; afterwards arbitration restarts at ptr=0.
        push(0, 8'hB1, 1'b0);
        push(0, 8'hB2, 1'b1);
        n = 0;
        while (tx_log.size() == 0 && n < 50) begin
            step();
            n++;
        end
        check_eq("first_byte_seen", tx_log.size(), 1);
        step();
        do_reset(1);
        tx_log.delete();
        push(0, 8'h77, 1'b1);
        push(2, 8'h88, 1'b1);
        drain(100);
        check_log("post_rst", 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 2);

        // External busy held high: grant may be taken but no byte moves.
        hold_busy = 1'b1;
        push(3, 8'h5A, 1'b1);
        repeat (8) begin
            step();
            @(negedge clk);
            check_eq("busy_no_ready", req_ready, 4'h0);
        end
        check_eq("busy_grant", grant_valid, 1'b1);
        hold_busy = 1'b0;
        drain(100);
        check_log("busy", 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1);

`ifdef UART_TX_ARB_WATCHDOG_EN
        // Requester 1 starves after a non-last byte; watchdog hands over to requester 2.
        do_reset(1);
        push(1, 8'h61, 1'b0);
        n = 0;
        while (tx_log.size() == 0 && n < 50) begin
            step();
            n++;
        end
        push(2, 8'h62, 1'b1);
        drain(200);
        check_log("wd", 8'h61, 8'h62, 8'h00, 8'h00, 8'h00, 2);
`endif

        // Randomised packet traffic with gated valids and random busy lengths.
        gate_en = 1'b1;
        total   = 0;
        repeat (4) begin
            for (int r = 0; r < N; r++) begin
                int np;
                np = $urandom_range(0, 4);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        push(r, 8'($urandom), (b == len - 1));
                        total++;
                    end
                end
            end
            drain(3000);
        end
        check_eq("random_byte_count", tx_log.size(), total);
        gate_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
